// File: rtl/nrisc_data_mem.sv
// nrisc_data_mem: responder for the CPU data port.
// Serves a synchronous word RAM at the bottom of the address space and a
// 16-word memory-mapped I/O window (GPIO, cycle timer, status) at IO_BASE.
// Single clock domain. Reads have a one-cycle latency. The RAM contents are
// not reset.
// Optional build macro: NRISC_DMEM_TIMER_EN enables the CYCLE/CMP timer and
// the IRQ it drives. When it is not defined, timer offsets read as reserved
// and IRQ is tied low.
//
// Strobe semantics: there is no valid/ready handshake. The responder is always
// ready. CORE_DATA_write and CORE_DATA_load are sampled at every posedge, and
// each posedge at which one is high is one complete access. A load returns the
// value the location held before that edge (read-first), in DATA_Out after the
// edge. DATA_Out holds its value until the next load. When rst is high at an
// edge, any access at that edge is discarded.
module nrisc_data_mem #(
    parameter int             TAM     = 16,
    parameter int             AW      = 8,
    parameter logic [TAM-1:0] IO_BASE = 16'hFFF0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [TAM-1:0] DATA_IN,
    output logic [TAM-1:0] DATA_Out,
    input  logic           CORE_DATA_write,
    input  logic           CORE_DATA_load,
    input  logic [TAM-1:0] CORE_DATA_ADDR,
    output logic [TAM-1:0] GPIO_OUT,
    input  logic [TAM-1:0] GPIO_IN,
    output logic           IRQ,
    output logic           ERR
);

    localparam logic [3:0] OFF_GPIO_OUT = 4'd0;
    localparam logic [3:0] OFF_GPIO_IN  = 4'd1;
    localparam logic [3:0] OFF_CYCLE    = 4'd2;
    localparam logic [3:0] OFF_CMP      = 4'd3;
    localparam logic [3:0] OFF_STATUS   = 4'd4;

    // Address decode. The I/O window takes priority over RAM if the two overlap.
    logic [3:0]    offset;
    logic [AW-1:0] ram_addr;
    logic          is_io;
    logic          is_ram;
    logic          is_unmapped;
    logic          io_wr;
    logic          status_wr;
    logic          err_set;

    assign offset      = CORE_DATA_ADDR[3:0];
    assign ram_addr    = CORE_DATA_ADDR[AW-1:0];
    assign is_io       = (CORE_DATA_ADDR[TAM-1:4] == IO_BASE[TAM-1:4]);
    assign is_ram      = !is_io && (CORE_DATA_ADDR[TAM-1:AW] == '0);
    assign is_unmapped = !is_io && !is_ram;
    assign io_wr       = CORE_DATA_write && is_io;
    assign status_wr   = io_wr && (offset == OFF_STATUS);
    assign err_set     = (CORE_DATA_write || CORE_DATA_load) && is_unmapped;

    logic [TAM-1:0] mem [0:(1<<AW)-1];
    logic [TAM-1:0] gpio_q;
    logic [TAM-1:0] gpio_sync1;
    logic [TAM-1:0] gpio_sync2;
    logic [TAM-1:0] io_rd;

    assign GPIO_OUT = gpio_q;

`ifdef NRISC_DMEM_TIMER_EN
    logic [TAM-1:0] cycle_q;
    logic [TAM-1:0] cmp_q;
    logic           irq_q;
    logic           irq_set;
    logic           irq_clr;

    assign irq_set = (cycle_q == cmp_q);
    assign irq_clr = status_wr && DATA_IN[0];
    assign IRQ     = irq_q;

    // Free-running cycle counter and compare register. A core write overrides the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            cmp_q   <= '1;
        end else begin
            if (io_wr && offset == OFF_CYCLE) cycle_q <= DATA_IN;
            else                              cycle_q <= cycle_q + TAM'(1);
            if (io_wr && offset == OFF_CMP)   cmp_q   <= DATA_IN;
        end
    end

    // Sticky match flag. A match in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst)          irq_q <= 1'b0;
        else if (irq_set) irq_q <= 1'b1;
        else if (irq_clr) irq_q <= 1'b0;
    end
`else
    assign IRQ = 1'b0;
`endif

    // RAM write port. Writes are dropped while rst is asserted.
    always_ff @(posedge clk) begin
        if (!rst && CORE_DATA_write && is_ram) mem[ram_addr] <= DATA_IN;
    end

    // GPIO output register and the two-flop synchroniser for the external inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_q     <= '0;
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
        end else begin
            if (io_wr && offset == OFF_GPIO_OUT) gpio_q <= DATA_IN;
            gpio_sync1 <= GPIO_IN;
            gpio_sync2 <= gpio_sync1;
        end
    end

    // Sticky unmapped-access flag. A new fault in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst)                           ERR <= 1'b0;
        else if (err_set)                  ERR <= 1'b1;
        else if (status_wr && DATA_IN[1])  ERR <= 1'b0;
    end

    // I/O read mux. Reserved offsets, and the timer offsets when the timer is absent, read as zero.
    always_comb begin
        io_rd = '0;
        case (offset)
            OFF_GPIO_OUT: io_rd = gpio_q;
            OFF_GPIO_IN:  io_rd = gpio_sync2;
`ifdef NRISC_DMEM_TIMER_EN
            OFF_CYCLE:    io_rd = cycle_q;
            OFF_CMP:      io_rd = cmp_q;
`endif
            OFF_STATUS:   io_rd = {{(TAM-2){1'b0}}, ERR, IRQ};
            default:      io_rd = '0;
        endcase
    end

    // Registered read data. The value is taken before any write at the same edge, and is held while load is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            DATA_Out <= '0;
        end else if (CORE_DATA_load) begin
            if (is_io)       DATA_Out <= io_rd;
            else if (is_ram) DATA_Out <= mem[ram_addr];
            else             DATA_Out <= '0;
        end
    end

endmodule

// File: doc/nrisc_data_mem.md
Name: nrisc_data_mem

Overview:
Responder side of the CPU data-memory interface. Accepts the core's write/load strobes, address and write data; serves a synchronous word RAM plus a small memory-mapped I/O window (GPIO, cycle timer, status). Sits between the CPU data port and the board pins; single clock domain, one-cycle read latency.

Parameters:
TAM, 16, data and address width in bits
AW, 8, RAM address bits; RAM depth is 2^AW words
IO_BASE, 16'hFFF0, base of the 16-word I/O window (low 4 bits must be 0)

Ports:
clk  in  1  main clock, all logic on posedge
rst  in  1  synchronous active-high reset
DATA_IN  in  TAM  write data from core
DATA_Out  out  TAM  read data to core (registered)
CORE_DATA_write  in  1  write strobe, sampled on posedge
CORE_DATA_load  in  1  load strobe, sampled on posedge
CORE_DATA_ADDR  in  TAM  word address
GPIO_OUT  out  TAM  general output register
GPIO_IN  in  TAM  asynchronous external inputs
IRQ  out  1  sticky timer-match flag
ERR  out  1  sticky unmapped-access flag

Behaviour:
- Reset (rst high at posedge): DATA_Out=0, GPIO_OUT=0, CYCLE=0, CMP=16'hFFFF, IRQ=0, ERR=0, GPIO_IN sync flops=0. RAM contents not reset.
- Decode per cycle:
  - IO: ADDR[TAM-1:4]==IO_BASE[TAM-1:4]; offset=ADDR[3:0].
  - RAM: ADDR < 2^AW.
  - Otherwise unmapped.
- Write (CORE_DATA_write=1): RAM word or IO register updated at that posedge; unmapped write ignored and sets ERR.
- Load (CORE_DATA_load=1): DATA_Out loaded at that posedge with the addressed value; visible after it (1-cycle latency). Unmapped load returns 0 and sets ERR.
- Load low: DATA_Out holds its last value.
- Write and load in the same cycle, same address: read-first; DATA_Out gets the pre-write value.
- IO map (offset):
  - 0 GPIO_OUT: R/W.
  - 1 GPIO_IN: read-only, value after a 2-flop synchroniser; writes ignored, no ERR.
  - 2 CYCLE: increments every cycle, wraps 16'hFFFF->0. A write loads DATA_IN and takes priority over the increment. A read returns the pre-increment value.
  - 3 CMP: R/W. When CYCLE==CMP (registered value), IRQ is set at the next posedge.
  - 4 STATUS: read returns {TAM-2 zeros, ERR, IRQ}. A write with bit0=1 clears IRQ; bit1=1 clears ERR. If a set and a clear hit the same cycle, set wins.
  - 5..15: reserved; read 0, write ignored, no ERR.
- IRQ and ERR remain set until cleared via STATUS or rst.
- rst asserted mid-access: the access is discarded; reset values apply at that posedge.

Optional Feature:
NRISC_DMEM_TIMER_EN
- Defined: CYCLE, CMP and IRQ logic present as above.
- Undefined:
  - Counter and compare registers are not instantiated.
  - Offsets 2 and 3 behave as reserved (read 0, write ignored).
  - IRQ is tied 0; STATUS bit0 reads 0.

Test Plan:
- RAM write/read: write 16'h1234 to addr 8'h05, then load addr 5 -> DATA_Out==16'h1234 one posedge after the load cycle; holds while load stays low.
- Read-first: RAM[3]=16'hAAAA; write 16'h5555 and load addr 3 in the same cycle -> DATA_Out==16'hAAAA; next load -> 16'h5555.
- Unmapped access: load addr 16'h0100 with AW=8 -> DATA_Out==0, ERR==1; write STATUS 16'h0002 -> ERR==0.
- GPIO: write 16'hBEEF to 16'hFFF0 -> GPIO_OUT==16'hBEEF. Drive GPIO_IN=16'h00C3, wait 2 cycles, load 16'hFFF1 -> DATA_Out==16'h00C3.
- Timer (macro on): write CYCLE=16'hFFFE, CMP=16'h0001 -> CYCLE wraps through 16'hFFFF to 0, IRQ rises one cycle after CYCLE==1. Write STATUS 16'h0001 -> IRQ==0. Macro off: IRQ stays 0 and load 16'hFFF2 returns 0.
- Reset mid-operation: assert rst together with a write of 16'h7777 to GPIO_OUT -> GPIO_OUT==0, DATA_Out==0, IRQ==0, ERR==0, CMP reads 16'hFFFF.
